// File: rtl/cmp_argmax_pkg.sv
// Shared defaults, result record and frame-state encoding for the streaming arg-max reducer.
`timescale 1ns/1ps
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
package cmp_argmax_pkg;

  localparam int DEF_DATA_BITS = `DATA_WIDTH;
  localparam int DEF_INDEX_BITS = 16;

  typedef struct packed {
    logic [DEF_DATA_BITS-1:0]  max;
    logic [DEF_INDEX_BITS-1:0] index;
    logic [DEF_INDEX_BITS-1:0] count;
    logic                      overflow;
  } result_t;

  typedef enum logic {
    FRAME_IDLE = 1'b0,
    FRAME_OPEN = 1'b1
  } frame_state_t;

endpackage

// File: rtl/cmp_argmax_stream_if.sv
// Element input stream and per-frame result stream of the arg-max reducer.
`timescale 1ns/1ps
interface cmp_argmax_stream_if #(
  parameter int DATA_BITS  = cmp_argmax_pkg::DEF_DATA_BITS,
  parameter int INDEX_BITS = cmp_argmax_pkg::DEF_INDEX_BITS
);
  logic [DATA_BITS-1:0]  s_data;
  logic                  s_last;
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_BITS-1:0]  m_max;
  logic [INDEX_BITS-1:0] m_index;
  logic [INDEX_BITS-1:0] m_count;
  logic                  m_overflow;
  logic                  m_valid;
  logic                  m_ready;

  modport master (
    output s_data, s_last, s_valid, m_ready,
    input  s_ready, m_max, m_index, m_count, m_overflow, m_valid
  );

  modport slave (
    input  s_data, s_last, s_valid, m_ready,
    output s_ready, m_max, m_index, m_count, m_overflow, m_valid
  );
endinterface

// File: rtl/cmp_argmax_update.sv
// Stage-2 running maximum: registered max/index with a strict unsigned greater-than compare.
`timescale 1ns/1ps
module cmp_argmax_update #(
  parameter int  INDEX_BITS = cmp_argmax_pkg::DEF_INDEX_BITS,
  parameter type data_t     = logic [cmp_argmax_pkg::DEF_DATA_BITS-1:0]
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_en,
  input  logic                  i_first,
  input  data_t                 i_data,
  input  logic [INDEX_BITS-1:0] i_cnt,
  output data_t                 o_max_next,
  output logic [INDEX_BITS-1:0] o_idx_next
);
  data_t                 r_max;
  logic [INDEX_BITS-1:0] r_idx;
  logic                  w_gt;

  // Strict compare so a tie keeps the earlier index.
  assign w_gt = (i_data > r_max);

  always_comb begin
    o_max_next = r_max;
    o_idx_next = r_idx;
    if (i_first) begin
      o_max_next = i_data;
      o_idx_next = '0;
    end else if (w_gt) begin
      o_max_next = i_data;
      o_idx_next = i_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_max <= '0;
      r_idx <= '0;
    end else if (i_en) begin
      r_max <= o_max_next;
      r_idx <= o_idx_next;
    end
  end

endmodule

// File: rtl/cmp_argmax_stream.sv
// Streaming arg-max reducer: input register, compare/accumulate stage and one result beat per frame.
`timescale 1ns/1ps
module cmp_argmax_stream
  import cmp_argmax_pkg::*;
#(
  parameter int  DATA_BITS  = DEF_DATA_BITS,
  parameter int  INDEX_BITS = DEF_INDEX_BITS,
  parameter type data_t     = logic [DATA_BITS-1:0]
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cke,
  cmp_argmax_stream_if.slave bus
);
  typedef logic [INDEX_BITS-1:0] idx_t;

  typedef struct packed {
    data_t max;
    idx_t  index;
    idx_t  count;
    logic  overflow;
  } res_t;

  localparam idx_t IDX_ONE = idx_t'(1);

  logic         w_stall;
  logic         w_s_ready;
  logic         w_accept;
  logic         w_adv;
  logic         w_st2_en;
  logic         w_first;

  data_t        r_st1_data;
  logic         r_st1_last;
  logic         r_st1_valid;

  frame_state_t r_state;
  frame_state_t w_state_next;

  idx_t         r_cnt;
  idx_t         w_cnt_inc;
  idx_t         w_cnt_next;
  logic         r_ovf;
  logic         w_ovf_next;

  data_t        w_max_next;
  idx_t         w_idx_next;

  res_t         r_res;
  logic         r_m_valid;

  // An unconsumed result freezes both pipeline stages.
  assign w_stall   = r_m_valid && !bus.m_ready;
  assign w_s_ready = cke && !w_stall && !reset;
  assign w_accept  = bus.s_valid && w_s_ready;
  assign w_adv     = cke && !w_stall;
  assign w_st2_en  = r_st1_valid && w_adv;
  assign w_first   = (r_state == FRAME_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_st1_valid <= 1'b0;
      r_st1_data  <= '0;
      r_st1_last  <= 1'b0;
    end else if (w_adv) begin
      r_st1_valid <= w_accept;
      if (w_accept) begin
        r_st1_data <= bus.s_data;
        r_st1_last <= bus.s_last;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FRAME_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (w_st2_en) begin
      w_state_next = r_st1_last ? FRAME_IDLE : FRAME_OPEN;
    end
  end

  // Count wraps modulo 2^INDEX_BITS; wrapping to zero marks the frame as overflowed.
  assign w_cnt_inc = r_cnt + IDX_ONE;

  always_comb begin
    w_cnt_next = w_cnt_inc;
    w_ovf_next = r_ovf | (w_cnt_inc == '0);
    if (w_first) begin
      w_cnt_next = IDX_ONE;
      w_ovf_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_st2_en) begin
      r_cnt <= w_cnt_next;
      r_ovf <= w_ovf_next;
    end
  end

  cmp_argmax_update #(
    .INDEX_BITS (INDEX_BITS),
    .data_t     (data_t)
  ) u_update (
    .clk        (clk),
    .reset      (reset),
    .i_en       (w_st2_en),
    .i_first    (w_first),
    .i_data     (r_st1_data),
    .i_cnt      (r_cnt),
    .o_max_next (w_max_next),
    .o_idx_next (w_idx_next)
  );

  // A new result may replace the one being consumed in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_res     <= '0;
      r_m_valid <= 1'b0;
    end else if (cke) begin
      if (w_st2_en && r_st1_last) begin
        r_res     <= '{max: w_max_next, index: w_idx_next, count: w_cnt_next, overflow: w_ovf_next};
        r_m_valid <= 1'b1;
      end else if (bus.m_ready) begin
        r_m_valid <= 1'b0;
      end
    end
  end

  assign bus.s_ready    = w_s_ready;
  assign bus.m_max      = r_res.max;
  assign bus.m_index    = r_res.index;
  assign bus.m_count    = r_res.count;
  assign bus.m_overflow = r_res.overflow;
  assign bus.m_valid    = r_m_valid;

endmodule

// File: tb/tb_cmp_argmax_stream.sv
// Directed bench for cmp_argmax_stream: a 32/16-bit instance plus a 4-bit-index instance for count wrap.
`timescale 1ns/1ps
module tb_cmp_argmax_stream;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic cke   = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc;

  cmp_argmax_stream_if #(.DATA_BITS(32), .INDEX_BITS(16)) bus ();
  cmp_argmax_stream_if #(.DATA_BITS(8),  .INDEX_BITS(4))  bus4 ();

  cmp_argmax_stream #(.DATA_BITS(32), .INDEX_BITS(16)) dut (
    .clk   (clk),
    .reset (reset),
    .cke   (cke),
    .bus   (bus)
  );

  cmp_argmax_stream #(.DATA_BITS(8), .INDEX_BITS(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .cke   (cke),
    .bus   (bus4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic last, input bit tog);
    logic done;
    done = 1'b0;
    bus.s_data  = d;
    bus.s_last  = last;
    bus.s_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (tog && !cke) chk("s_ready_cke_low", bus.s_ready, 1'b0);
      done = bus.s_ready;
      @(posedge clk);
      #1;
      if (tog) cke = ~cke;
      if (done) break;
    end
    bus.s_valid = 1'b0;
    chk("send_accepted", done, 1'b1);
  endtask

  task automatic send4(input logic [7:0] d, input logic last);
    logic done;
    done = 1'b0;
    bus4.s_data  = d;
    bus4.s_last  = last;
    bus4.s_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      done = bus4.s_ready;
      @(posedge clk);
      #1;
      if (done) break;
    end
    bus4.s_valid = 1'b0;
    chk("send4_accepted", done, 1'b1);
  endtask

  task automatic wait_mv(output int c);
    c = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.m_valid) begin
        c = i;
        break;
      end
    end
    chk("m_valid_seen", bus.m_valid, 1'b1);
  endtask

  task automatic wait_mv4();
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus4.m_valid) break;
    end
    chk("m_valid4_seen", bus4.m_valid, 1'b1);
  endtask

  initial begin
    bus.s_data   = '0;
    bus.s_last   = 1'b0;
    bus.s_valid  = 1'b0;
    bus.m_ready  = 1'b1;
    bus4.s_data  = '0;
    bus4.s_last  = 1'b0;
    bus4.s_valid = 1'b0;
    bus4.m_ready = 1'b1;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready",  bus.s_ready,    1'b0);
    chk("rst_m_valid",  bus.m_valid,    1'b0);
    chk("rst_m_max",    bus.m_max,      32'd0);
    chk("rst_m_index",  bus.m_index,    16'd0);
    chk("rst_m_count",  bus.m_count,    16'd0);
    chk("rst_m_ovf",    bus.m_overflow, 1'b0);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("idle_s_ready", bus.s_ready, 1'b1);
    step();

    // frame 3,9,2,9,5 with a tie on 9
    send(32'd3, 1'b0, 1'b0);
    send(32'd9, 1'b0, 1'b0);
    send(32'd2, 1'b0, 1'b0);
    send(32'd9, 1'b0, 1'b0);
    send(32'd5, 1'b1, 1'b0);
    wait_mv(cyc);
    chk("f1_latency", cyc, 2);
    chk("f1_max",   bus.m_max,      32'd9);
    chk("f1_index", bus.m_index,    16'd1);
    chk("f1_count", bus.m_count,    16'd5);
    chk("f1_ovf",   bus.m_overflow, 1'b0);
    @(negedge clk);
    chk("f1_consumed", bus.m_valid, 1'b0);
    step();

    // single-beat frame at full scale, then a fresh two-beat frame
    send(32'hFFFF_FFFF, 1'b1, 1'b0);
    wait_mv(cyc);
    chk("f2_latency", cyc, 2);
    chk("f2_max",   bus.m_max,   32'hFFFF_FFFF);
    chk("f2_index", bus.m_index, 16'd0);
    chk("f2_count", bus.m_count, 16'd1);
    step();
    send(32'd1, 1'b0, 1'b0);
    send(32'd2, 1'b1, 1'b0);
    wait_mv(cyc);
    chk("f3_max",   bus.m_max,   32'd2);
    chk("f3_index", bus.m_index, 16'd1);
    chk("f3_count", bus.m_count, 16'd2);
    step();

    // back-pressure: A=4,7 held while B=5,8,1 is offered
    bus.m_ready = 1'b0;
    send(32'd4, 1'b0, 1'b0);
    send(32'd7, 1'b1, 1'b0);
    send(32'd5, 1'b0, 1'b0);
    bus.s_data  = 32'd8;
    bus.s_last  = 1'b0;
    bus.s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_s_ready", bus.s_ready,  1'b0);
      chk("stall_m_valid", bus.m_valid,  1'b1);
      chk("stall_max",     bus.m_max,    32'd7);
      chk("stall_index",   bus.m_index,  16'd1);
      chk("stall_count",   bus.m_count,  16'd2);
    end
    step();
    bus.m_ready = 1'b1;
    send(32'd8, 1'b0, 1'b0);
    send(32'd1, 1'b1, 1'b0);
    wait_mv(cyc);
    chk("fb_max",   bus.m_max,   32'd8);
    chk("fb_index", bus.m_index, 16'd1);
    chk("fb_count", bus.m_count, 16'd3);
    step();

    // clock enable toggling every cycle during frame 10,20,30
    send(32'd10, 1'b0, 1'b1);
    send(32'd20, 1'b0, 1'b1);
    send(32'd30, 1'b1, 1'b1);
    cke = 1'b1;
    wait_mv(cyc);
    chk("cke_max",   bus.m_max,   32'd30);
    chk("cke_index", bus.m_index, 16'd2);
    chk("cke_count", bus.m_count, 16'd3);
    step();

    // 4-bit index: 17 elements 1..16,100 wrap the count
    for (int i = 0; i < 16; i++) send4(8'(i + 1), 1'b0);
    send4(8'd100, 1'b1);
    wait_mv4();
    chk("wrap_max",   bus4.m_max,      8'd100);
    chk("wrap_index", bus4.m_index,    4'd0);
    chk("wrap_count", bus4.m_count,    4'd1);
    chk("wrap_ovf",   bus4.m_overflow, 1'b1);
    step();
    send4(8'd3, 1'b0);
    send4(8'd5, 1'b1);
    wait_mv4();
    chk("post_wrap_max",   bus4.m_max,      8'd5);
    chk("post_wrap_index", bus4.m_index,    4'd1);
    chk("post_wrap_count", bus4.m_count,    4'd2);
    chk("post_wrap_ovf",   bus4.m_overflow, 1'b0);
    step();

    // reset after two beats discards the partial frame
    send(32'd50, 1'b0, 1'b0);
    send(32'd60, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_s_ready", bus.s_ready, 1'b0);
    step();
    @(negedge clk);
    chk("mid_rst_max",     bus.m_max,      32'd0);
    chk("mid_rst_index",   bus.m_index,    16'd0);
    chk("mid_rst_count",   bus.m_count,    16'd0);
    chk("mid_rst_ovf",     bus.m_overflow, 1'b0);
    chk("mid_rst_m_valid", bus.m_valid,    1'b0);
    chk("mid_rst_s_ready2", bus.s_ready,   1'b0);
    step();
    reset = 1'b0;
    send(32'd6, 1'b0, 1'b0);
    send(32'd1, 1'b1, 1'b0);
    wait_mv(cyc);
    chk("after_rst_max",   bus.m_max,      32'd6);
    chk("after_rst_index", bus.m_index,    16'd0);
    chk("after_rst_count", bus.m_count,    16'd2);
    chk("after_rst_ovf",   bus.m_overflow, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
